// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - data-memory request/ready bus between the LSU and memory
interface lsu_mem_port_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_be,
      output mem_wdata,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_be,
      input  mem_wdata,
      output mem_ready,
      output mem_rdata
   );
endinterface

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - M-stage load/store unit with registered memory handshake and stall
module lsu_mem_port #(
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           MemWriteM,
   input  logic           MemReadM,
   input  logic [31:0]    ALUResultM,
   input  logic [31:0]    WriteDataM,
   input  logic [2:0]     funct3M,
   output logic [31:0]    ReadData,
   output logic           StallMem,
   lsu_mem_port_if.master bus,
   output logic           align_err,
   output logic           bus_err,
   input  logic           err_clr
);

   localparam logic [9:0] TMO = 10'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;
   logic        align_err_q, align_err_d;
   logic        bus_err_q, bus_err_d;

   logic        access, illegal, misal, acc_bad, acc_ok;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;

   // Shift the raw word down to the addressed lane, then sign- or zero-extend.
   function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  off);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b010:  return word;
         3'b100:  return {24'h0, sh[7:0]};
         3'b101:  return {16'h0, sh[15:0]};
         default: return 32'h0;
      endcase
   endfunction

   // Decode the M-stage access: legality, alignment, byte enables and lane-replicated data.
   always_comb begin
      access    = MemWriteM | MemReadM;
      illegal   = (funct3M == 3'b011) || (funct3M[2:1] == 2'b11) || (MemWriteM && funct3M[2]);
      misal     = 1'b0;
      be_new    = 4'b1111;
      wdata_new = 32'h0;
      case (funct3M[1:0])
         2'b01:   misal = ALUResultM[0];
         2'b10:   misal = |ALUResultM[1:0];
         default: misal = 1'b0;
      endcase
      acc_bad = access & (illegal | misal);
      acc_ok  = access & ~(illegal | misal);
      // A store wins when both controls are raised, so only MemWriteM selects store lanes.
      if (MemWriteM) begin
         case (funct3M[1:0])
            2'b00: begin
               be_new    = 4'b0001 << ALUResultM[1:0];
               wdata_new = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
               be_new    = 4'b0011 << {ALUResultM[1], 1'b0};
               wdata_new = {2{WriteDataM[15:0]}};
            end
            default: begin
               be_new    = 4'b1111;
               wdata_new = WriteDataM;
            end
         endcase
      end
   end

   // Next-state, bus capture, sticky flags and pipeline-facing outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      f3_d        = f3_q;
      off_d       = off_q;
      rdata_d     = rdata_q;
      align_err_d = err_clr ? 1'b0 : align_err_q;
      bus_err_d   = err_clr ? 1'b0 : bus_err_q;
      StallMem    = 1'b0;
      ReadData    = rdata_q;
      case (state_q)
         IDLE: begin
            cnt_d = 10'd0;
            if (acc_bad) begin
               // Bad access never reaches the bus; a new error beats a same-cycle clear.
               align_err_d = 1'b1;
               ReadData    = 32'h0;
            end else if (acc_ok) begin
               StallMem = 1'b1;
               req_d    = 1'b1;
               we_d     = MemWriteM;
               addr_d   = {ALUResultM[31:2], 2'b00};
               be_d     = be_new;
               wdata_d  = wdata_new;
               f3_d     = funct3M;
               off_d    = ALUResultM[1:0];
               state_d  = REQ;
            end
         end
         REQ: begin
            StallMem = 1'b1;
            cnt_d    = cnt_q + 10'd1;
            if (bus.mem_ready) begin
               req_d   = 1'b0;
               if (!we_q) begin
                  rdata_d = fmt_load(bus.mem_rdata, f3_q, off_q);
               end
               state_d = DONE;
            end else if (cnt_q == TMO) begin
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               rdata_d   = 32'h0;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and captured-access registers; async reset abandons any outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 10'd0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'h0;
         be_q        <= 4'h0;
         wdata_q     <= 32'h0;
         f3_q        <= 3'h0;
         off_q       <= 2'h0;
         rdata_q     <= 32'h0;
         align_err_q <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         rdata_q     <= rdata_d;
         align_err_q <= align_err_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_be    = be_q;
   assign bus.mem_wdata = wdata_q;
   assign align_err     = align_err_q;
   assign bus_err       = bus_err_q;

endmodule
